dsm_bitstream_modulator: RTL
============================

// Module: dsm_bitstream_modulator
// PURPOSE
//  Digital 2nd-order delta-sigma modulator: the DAC-side counterpart of the CIC decimation path.
//  Accepts signed PCM samples at the decimated rate and emits one 1-bit density-coded output per clk.
//  Each sample is held for OSR clocks (zero-order hold); output drives a pin or loops into the decimator.
// PARAMETERS
//  DATA_W  16  PCM sample width, two's complement
//  OSR     64  clocks per sample; power of two, >= 4
//  IW      DATA_W+6  integrator width (derived; do not override)
// PORTS
//  clk          in   1       single clock; all state on rising edge
//  rst          in   1       synchronous, active-high reset
//  in_data      in   DATA_W  signed PCM sample
//  in_valid     in   1       sample offered
//  in_ready     out  1       block can accept; transfer when in_valid & in_ready
//  bit_out      out  1       modulated bitstream, registered
//  sample_tick  out  1       1-clk pulse on the last clk of each OSR frame (active sample loads next)
//  underrun     out  1       sticky: frame boundary reached with no pending sample
//  sat          out  1       sticky: an integrator clipped
//  clr_status   in   1       clears underrun and sat next clk (set wins if same clk)
// BEHAVIOUR
//  Reset: i1=i2=0, bit_out=0, phase=0, active=0, pending empty, in_ready=1, sample_tick=0, flags=0.
//  Phase counter: 0..OSR-1, wraps; sample_tick = (phase==OSR-1), registered-equivalent, no glitch.
//  Buffer: one-deep pending reg; in_ready = ~pending_full. Accepted sample lands in pending.
//  At phase==OSR-1: active<=pending, pending cleared. Pending empty -> active holds, underrun<=1.
//  Accept on phase==OSR-1 with pending empty: sample bypasses straight into active, no underrun,
//   pending stays empty, in_ready stays 1.
//  First sample after reset enters active only at a frame boundary; bit_out runs on active=0 until then.
//  Loop, every clk: fb = bit_out ? +2^(DATA_W-1) : -2^(DATA_W-1) (sign-extended to IW).
//   i1_n = sat(i1 + active - fb); i2_n = sat(i2 + i1 - fb)  (i2 uses OLD i1).
//   bit_out <= (q >= 0), q = i2_n (+ dither if enabled).
//  sat(): clamp to [-2^(IW-1), 2^(IW-1)-1]; any clamp sets sat flag.
//  Stable input range |x| <= 0.75*FS; beyond that the sat flag is expected.
//  Latency: change of active reflected in bit_out density from next clk; sample -> active
//   <= 2*OSR clks.
//  rst mid-frame: everything returns to reset values, including pending sample (dropped).
// CONFIGURATION
//  DSM_MOD_DITHER_EN defined: 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on rst,
//   steps every clk; dither = {lfsr[3:0]} - 8 (range -8..+7), sign-extended, added to q only
//   (not to the integrators).
//  Undefined: no LFSR flops, q = i2_n exactly; output bit-exact to the reference model.
// STRUCTURE
//  Package dsm_mod_pkg: DATA_W/OSR defaults, IW derivation, FS_POS/FS_NEG constants,
//   LFSR seed/tap mask, sat() function.
//  Sub-module dsm_mod_loop: integrators, quantiser, fb, optional dither; ports clk, rst,
//   x, bit_out, sat_pulse. Top holds phase counter, pending/active regs, flags.
// TESTING
//  1 rst, no input, 1024 clks -> ones count 512 +/-2; underrun=1 after first boundary;
//    sample_tick every 64 clks.
//  2 in_data=+16384 held by refill each frame, 4096 clks -> ones 3072 +/-8; sat=0, underrun=0.
//  3 in_data=-24576 (-0.75FS) -> ones density 12.5% +/-1%; sat=0.
//  4 offer two samples back-to-back mid-frame -> first accepted, in_ready=0 until boundary,
//    second accepted next clk after tick.
//  5 offer sample exactly on phase==63 with pending empty -> active updates, underrun stays 0.
//  6 in_data=+32767 -> sat=1; clr_status -> 0 then re-sets; rst mid-frame -> all outputs at
//    reset values next clk.
//  With DSM_MOD_DITHER_EN: rerun 1-3; densities within same tolerance; zero-input
//    pattern not period-2.

Source files
------------

// File: rtl/dsm_mod_pkg.sv
// Shared definitions for the 2nd-order delta-sigma bitstream modulator.
//   - Default sample width / oversampling ratio and integrator width derivation
//   - Full-scale feedback magnitude helper
//   - LFSR seed and tap mask for the optional dither (macro DSM_MOD_DITHER_EN)
//   - sat_clip(): clamp a wide value to a signed integrator range, reporting a clip
package dsm_mod_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned OSR_DEF    = 64;
  // Integrator headroom above the sample width.
  localparam int unsigned IW_EXTRA   = 6;

  function automatic int unsigned iw_of(input int unsigned data_w);
    return data_w + IW_EXTRA;
  endfunction

  // Feedback magnitude: 2^(data_w-1).
  function automatic longint fs_pos(input int unsigned data_w);
    return longint'(1) <<< (data_w - 1);
  endfunction

  localparam longint FS_POS = fs_pos(DATA_W_DEF);
  localparam longint FS_NEG = -FS_POS;

  // Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic signed [63:0] val;
    logic               hit;
  } sat_res_t;

  // Clamp v to [-2^(iw-1), 2^(iw-1)-1]; hit flags that clamping happened.
  function automatic sat_res_t sat_clip(input longint v, input int unsigned iw);
    longint   hi;
    longint   lo;
    sat_res_t res;
    hi = (longint'(1) <<< (iw - 1)) - 64'sd1;
    lo = -(longint'(1) <<< (iw - 1));
    res.hit = 1'b1;
    if (v > hi) begin
      res.val = hi;
    end else if (v < lo) begin
      res.val = lo;
    end else begin
      res.val = v;
      res.hit = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/dsm_mod_loop.sv
// Noise-shaping loop of the delta-sigma modulator: two saturating integrators,
// 1-bit quantiser and +/-full-scale feedback. Optional LFSR dither on the
// quantiser input only, enabled by defining DSM_MOD_DITHER_EN.
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   x          in   signed loop input (held sample)
//   bit_out    out  registered quantiser output
//   sat_pulse  out  an integrator clips on this clock's update
module dsm_mod_loop
  import dsm_mod_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x,
  output logic              bit_out,
  output logic              sat_pulse
);

  localparam int unsigned IW     = iw_of(DATA_W);
  localparam longint      FB_MAG = fs_pos(DATA_W);

  logic signed [IW-1:0] r_i1;
  logic signed [IW-1:0] r_i2;
  logic                 r_bit;

  longint               w_fb;
  longint               w_dither;
  longint               w_q;
  sat_res_t             w_s1;
  sat_res_t             w_s2;
  logic signed [IW-1:0] w_i1_n;
  logic signed [IW-1:0] w_i2_n;
  logic                 w_bit_n;

`ifdef DSM_MOD_DITHER_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
    end
  end

  // Range -8..+7.
  assign w_dither = longint'({1'b0, r_lfsr[3:0]}) - 64'sd8;
`else
  assign w_dither = 64'sd0;
`endif

  always_comb begin
    w_fb    = r_bit ? FB_MAG : -FB_MAG;
    // Second integrator consumes the old first-integrator value.
    w_s1    = sat_clip(longint'(r_i1) + longint'($signed(x)) - w_fb, IW);
    w_s2    = sat_clip(longint'(r_i2) + longint'(r_i1) - w_fb, IW);
    w_i1_n  = w_s1.val[IW-1:0];
    w_i2_n  = w_s2.val[IW-1:0];
    w_q     = longint'(w_i2_n) + w_dither;
    w_bit_n = (w_q >= 64'sd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_i1  <= '0;
      r_i2  <= '0;
      r_bit <= 1'b0;
    end else begin
      r_i1  <= w_i1_n;
      r_i2  <= w_i2_n;
      r_bit <= w_bit_n;
    end
  end

  assign bit_out   = r_bit;
  assign sat_pulse = w_s1.hit | w_s2.hit;

endmodule

// File: rtl/dsm_bitstream_modulator.sv
// 2nd-order delta-sigma bitstream modulator (DAC side of the CIC path).
// PCM samples are handshaked into a one-deep pending buffer, promoted to the
// active (zero-order-held) sample at each OSR frame boundary, and modulated
// into a 1-bit density-coded stream. Build option DSM_MOD_DITHER_EN adds LFSR
// dither at the quantiser (see dsm_mod_loop).
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   in_data       signed PCM sample, in_valid/in_ready handshake
//   bit_out       registered modulated bitstream
//   sample_tick   1-clk pulse on the last clk of each frame
//   underrun      sticky: boundary reached with no sample available
//   sat           sticky: an integrator clipped
//   clr_status    clears both sticky flags (a same-clk set wins)
module dsm_bitstream_modulator
  import dsm_mod_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned OSR    = OSR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bit_out,
  output logic              sample_tick,
  output logic              underrun,
  output logic              sat,
  input  logic              clr_status
);

  localparam int unsigned    PW        = $clog2(OSR);
  localparam logic [PW-1:0]  PHASE_PRE = PW'(OSR - 2);

  logic [PW-1:0]     r_phase;
  logic              r_tick;
  logic [DATA_W-1:0] r_pend;
  logic              r_pend_full;
  logic [DATA_W-1:0] r_active;
  logic              r_underrun;
  logic              r_sat;

  logic [PW-1:0]     w_phase_d;
  logic              w_tick_d;
  logic              w_accept;
  logic [DATA_W-1:0] w_pend_d;
  logic              w_pend_full_d;
  logic [DATA_W-1:0] w_active_d;
  logic              w_underrun_set;
  logic              w_underrun_d;
  logic              w_sat_d;
  logic              w_sat_pulse;

  always_comb begin
    w_phase_d      = r_phase + PW'(1);
    // Registered tick: high exactly while phase == OSR-1.
    w_tick_d       = (r_phase == PHASE_PRE);
    w_accept       = in_valid & ~r_pend_full;
    w_pend_d       = r_pend;
    w_pend_full_d  = r_pend_full;
    w_active_d     = r_active;
    w_underrun_set = 1'b0;
    if (r_tick) begin
      if (r_pend_full) begin
        w_active_d    = r_pend;
        w_pend_full_d = 1'b0;
      end else if (w_accept) begin
        // Sample offered right on the boundary goes straight to active.
        w_active_d = in_data;
      end else begin
        w_underrun_set = 1'b1;
      end
    end else if (w_accept) begin
      w_pend_d      = in_data;
      w_pend_full_d = 1'b1;
    end
    w_underrun_d = w_underrun_set | (r_underrun & ~clr_status);
    w_sat_d      = w_sat_pulse | (r_sat & ~clr_status);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase     <= '0;
      r_tick      <= 1'b0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_active    <= '0;
      r_underrun  <= 1'b0;
      r_sat       <= 1'b0;
    end else begin
      r_phase     <= w_phase_d;
      r_tick      <= w_tick_d;
      r_pend      <= w_pend_d;
      r_pend_full <= w_pend_full_d;
      r_active    <= w_active_d;
      r_underrun  <= w_underrun_d;
      r_sat       <= w_sat_d;
    end
  end

  dsm_mod_loop #(
    .DATA_W (DATA_W)
  ) u_loop (
    .clk       (clk),
    .rst       (rst),
    .x         (r_active),
    .bit_out   (bit_out),
    .sat_pulse (w_sat_pulse)
  );

  assign in_ready    = ~r_pend_full;
  assign sample_tick = r_tick;
  assign underrun    = r_underrun;
  assign sat         = r_sat;

endmodule
